// File: rtl/gpio_pad_bank.sv
// GPIO pad bank: register bus, per-pin input synchroniser, optional glitch filter,
// edge-detect interrupts with W1C status. Define GPIO_GLITCH_FILTER_EN to build the filter.
module gpio_pad_bank #(
  parameter int N_PINS      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        reg_addr,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  input  logic [N_PINS-1:0] pad_c,
  output logic [N_PINS-1:0] pad_i,
  output logic [N_PINS-1:0] pad_oen,
  output logic              irq_o
);

  typedef enum logic [2:0] {
    ADDR_OUT        = 3'd0,
    ADDR_DIR        = 3'd1,
    ADDR_IN         = 3'd2,
    ADDR_IRQ_EN     = 3'd3,
    ADDR_IRQ_RISE   = 3'd4,
    ADDR_IRQ_BOTH   = 3'd5,
    ADDR_IRQ_STATUS = 3'd6,
    ADDR_FILTER     = 3'd7
  } addr_e;

  localparam int               ARM_CYCLES = SYNC_STAGES + 2;
  localparam int               ARM_W      = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_DONE   = ARM_W'(ARM_CYCLES);

  addr_e             addr;
  logic [N_PINS-1:0] wdata;
  logic [N_PINS-1:0] out_q, dir_q, en_q, rise_q, both_q, status_q;
  logic [N_PINS-1:0] sync_q [SYNC_STAGES];
  logic [N_PINS-1:0] sync, filt, prev_q;
  logic [N_PINS-1:0] rise, fall, hit_sel, hit, w1c;
  logic [ARM_W-1:0]  arm_cnt;
  logic              armed;
  logic [31:0]       filter_rd;
  logic [31:0]       rd_mux;

  assign addr  = addr_e'(reg_addr);
  assign wdata = reg_wdata[N_PINS-1:0];

  // Control registers; IN and IRQ_STATUS are not plain storage and live elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      dir_q  <= '0;
      en_q   <= '0;
      rise_q <= '0;
      both_q <= '0;
    end else if (reg_we) begin
      // NOTE: non-blocking so every flop samples pre-edge values whatever the block order.
      case (addr)
        ADDR_OUT:      out_q  <= wdata;
        ADDR_DIR:      dir_q  <= wdata;
        ADDR_IRQ_EN:   en_q   <= wdata;
        ADDR_IRQ_RISE: rise_q <= wdata;
        ADDR_IRQ_BOTH: both_q <= wdata;
        default: ;
      endcase
    end
  end

  assign pad_i   = out_q;
  assign pad_oen = ~dir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every synchroniser stage is reset so IN reads 0 straight out of reset.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pad_c;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_GLITCH_FILTER_EN
  logic [FILT_CNT_W-1:0] thr_q;
  logic [FILT_CNT_W-1:0] cnt_q [N_PINS];
  logic [N_PINS-1:0]     filt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_q <= '0;
    end else if (reg_we && addr == ADDR_FILTER) begin
      thr_q <= reg_wdata[FILT_CNT_W-1:0];
    end
  end

  // A pin's filtered value follows sync only after T+1 consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= '0;
      for (int p = 0; p < N_PINS; p++) cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < N_PINS; p++) begin
        if (sync[p] == filt_q[p]) begin
          cnt_q[p] <= '0;
        end else if (cnt_q[p] == thr_q) begin
          filt_q[p] <= sync[p];
          cnt_q[p]  <= '0;
        end else begin
          cnt_q[p] <= cnt_q[p] + FILT_CNT_W'(1);
        end
      end
    end
  end

  assign filt      = filt_q;
  assign filter_rd = 32'(thr_q);
`else
  assign filt      = sync;
  assign filter_rd = 32'({FILT_CNT_W{1'b0}});
`endif

  // Edges are ignored until the synchroniser and filter have flushed their reset values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= '0;
      prev_q  <= '0;
    end else begin
      prev_q <= filt;
      if (arm_cnt != ARM_DONE) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign armed   = (arm_cnt == ARM_DONE);
  assign rise    = filt & ~prev_q;
  assign fall    = ~filt & prev_q;
  assign hit_sel = (both_q & (rise | fall)) | (~both_q & ((rise_q & rise) | (~rise_q & fall)));
  assign hit     = armed ? hit_sel : '0;
  assign w1c     = (reg_we && addr == ADDR_IRQ_STATUS) ? wdata : '0;

  // A new hit in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) status_q <= '0;
    else       status_q <= (status_q & ~w1c) | hit;
  end

  assign irq_o = |(status_q & en_q);

  always_comb begin
    // NOTE: default assigned first so no path leaves rd_mux unassigned (no latch).
    rd_mux = '0;
    case (addr)
      ADDR_OUT:        rd_mux = 32'(out_q);
      ADDR_DIR:        rd_mux = 32'(dir_q);
      ADDR_IN:         rd_mux = 32'(filt);
      ADDR_IRQ_EN:     rd_mux = 32'(en_q);
      ADDR_IRQ_RISE:   rd_mux = 32'(rise_q);
      ADDR_IRQ_BOTH:   rd_mux = 32'(both_q);
      ADDR_IRQ_STATUS: rd_mux = 32'(status_q);
      ADDR_FILTER:     rd_mux = filter_rd;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       reg_rdata <= '0;
    else if (reg_re) reg_rdata <= rd_mux;
  end

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Self-checking bench for gpio_pad_bank: directed steps plus random traffic against a
// cycle-level behavioural model; works with or without GPIO_GLITCH_FILTER_EN.
module tb_gpio_pad_bank;

  localparam int N_PINS      = 32;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CNT_W  = 4;
`ifdef GPIO_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  // Pad-to-status latency with T=0.
  localparam int LAT = FILT_ON ? SYNC_STAGES + 2 : SYNC_STAGES + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        reg_addr;
  logic              reg_we;
  logic              reg_re;
  logic [31:0]       reg_wdata;
  logic [31:0]       reg_rdata;
  logic [N_PINS-1:0] pad_c;
  logic [N_PINS-1:0] pad_i;
  logic [N_PINS-1:0] pad_oen;
  logic              irq_o;

  gpio_pad_bank #(
    .N_PINS      (N_PINS),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CNT_W  (FILT_CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .pad_c     (pad_c),
    .pad_i     (pad_i),
    .pad_oen   (pad_oen),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [31:0] m_out, m_dir, m_en, m_rise, m_both, m_status, m_filt, m_prev, m_rdata;
  logic [31:0] m_padq[$];
  int          m_run[N_PINS];
  int          m_thr;
  int          m_age;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_en = '0; m_rise = '0; m_both = '0;
    m_status = '0; m_filt = '0; m_prev = '0; m_rdata = '0;
    m_padq.delete();
    for (int p = 0; p < N_PINS; p++) m_run[p] = 0;
    m_thr = 0;
    m_age = 0;
  endtask

  function automatic logic [31:0] cur_sync();
    return (m_padq.size() == SYNC_STAGES) ? m_padq[0] : 32'h0;
  endfunction

  // One clock edge of the model, using the inputs the bench presented before the edge.
  task automatic model_edge();
    logic [31:0] sync, f_now, nfilt, rise, fall, hit, w1c;
    sync  = cur_sync();
    f_now = FILT_ON ? m_filt : sync;
    nfilt = m_filt;
    for (int p = 0; p < N_PINS; p++) begin
      if (sync[p] == m_filt[p]) m_run[p] = 0;
      else if (m_run[p] == m_thr) begin nfilt[p] = sync[p]; m_run[p] = 0; end
      else m_run[p] = (m_run[p] + 1) % (1 << FILT_CNT_W);
    end
    rise = f_now & ~m_prev;
    fall = ~f_now & m_prev;
    hit  = '0;
    for (int p = 0; p < N_PINS; p++) begin
      if (m_both[p])      hit[p] = rise[p] | fall[p];
      else if (m_rise[p]) hit[p] = rise[p];
      else                hit[p] = fall[p];
    end
    if (m_age < SYNC_STAGES + 2) hit = '0;
    if (reg_re) begin
      case (reg_addr)
        3'd0: m_rdata = m_out;
        3'd1: m_rdata = m_dir;
        3'd2: m_rdata = f_now;
        3'd3: m_rdata = m_en;
        3'd4: m_rdata = m_rise;
        3'd5: m_rdata = m_both;
        3'd6: m_rdata = m_status;
        default: m_rdata = FILT_ON ? 32'(m_thr) : 32'h0;
      endcase
    end
    w1c = (reg_we && reg_addr == 3'd6) ? reg_wdata : 32'h0;
    if (reg_we) begin
      case (reg_addr)
        3'd0: m_out  = reg_wdata;
        3'd1: m_dir  = reg_wdata;
        3'd3: m_en   = reg_wdata;
        3'd4: m_rise = reg_wdata;
        3'd5: m_both = reg_wdata;
        3'd7: if (FILT_ON) m_thr = int'(reg_wdata[FILT_CNT_W-1:0]);
        default: ;
      endcase
    end
    m_status = (m_status & ~w1c) | hit;
    m_padq.push_back(pad_c);
    if (m_padq.size() > SYNC_STAGES) void'(m_padq.pop_front());
    m_filt = FILT_ON ? nfilt : 32'h0;
    m_prev = f_now;
    m_age++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pad_i", pad_i, m_out);
    check("pad_oen", pad_oen, ~m_dir);
    check("irq_o", {31'b0, irq_o}, {31'b0, |(m_status & m_en)});
    check("reg_rdata", reg_rdata, m_rdata);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    reg_addr = a; reg_re = 1'b1;
    tick();
    reg_re = 1'b0;
    d = reg_rdata;
  endtask

  task automatic apply_reset();
    reset = 1'b1; reg_we = 1'b0; reg_re = 1'b0;
    model_reset();
    #1;
    check("rst_pad_oen", pad_oen, 32'hFFFF_FFFF);
    check("rst_pad_i", pad_i, 32'h0);
    check("rst_irq_o", {31'b0, irq_o}, 32'h0);
    check("rst_rdata", reg_rdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          hi_cnt;
    reset = 1'b1; reg_addr = '0; reg_we = 1'b0; reg_re = 1'b0; reg_wdata = '0; pad_c = '0;

    // Reset values and output drive.
    apply_reset();
    repeat (6) tick();
    bus_write(3'd1, 32'h0000_FF00);
    check("dir_pad_oen", pad_oen, 32'hFFFF_00FF);
    bus_write(3'd0, 32'h0000_A500);
    check("out_pad_i", pad_i, 32'h0000_A500);

    // Rising edge on pin 3 with T=0; exact latency, then W1C.
    bus_write(3'd3, 32'h8);
    bus_write(3'd4, 32'h8);
    pad_c[3] = 1'b1;
    repeat (LAT - 1) tick();
    check("irq_early", {31'b0, irq_o}, 32'h0);
    tick();
    check("irq_latency", {31'b0, irq_o}, 32'h1);
    bus_read(3'd6, rd);
    check("status_rise", rd, 32'h8);
    bus_write(3'd6, 32'h8);
    check("w1c_drop", {31'b0, irq_o}, 32'h0);

    // Both edges on pin 1, then W1C colliding with a new hit.
    bus_write(3'd5, 32'h2);
    pad_c[1] = 1'b1;
    repeat (LAT + 1) tick();
    bus_write(3'd6, 32'h2);
    pad_c[1] = 1'b0;
    repeat (LAT + 1) tick();
    bus_read(3'd6, rd);
    check("both_fall", rd & 32'h2, 32'h2);
    bus_write(3'd6, 32'h2);
    pad_c[1] = 1'b1;
    repeat (LAT - 1) tick();
    bus_write(3'd6, 32'h2);
    bus_read(3'd6, rd);
    check("set_wins", rd & 32'h2, 32'h2);
    bus_write(3'd6, 32'hFFFF_FFFF);

    // Glitch filter with T=3: 3-cycle pulse rejected, 5-cycle pulse passes.
    bus_write(3'd7, 32'h3);
    bus_read(3'd7, rd);
    check("filter_reg", rd, FILT_ON ? 32'h3 : 32'h0);
    reg_addr = 3'd2; reg_re = 1'b1; hi_cnt = 0;
    pad_c[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) pad_c[0] = 1'b0;
      tick();
      if (reg_rdata[0]) hi_cnt++;
    end
    reg_re = 1'b0;
    check("glitch_in_cycles", 32'(hi_cnt), FILT_ON ? 32'd0 : 32'd3);
    bus_read(3'd6, rd);
    check("glitch_status", rd & 32'h1, FILT_ON ? 32'h0 : 32'h1);
    bus_write(3'd6, 32'h1);
    reg_addr = 3'd2; reg_re = 1'b1; hi_cnt = 0;
    pad_c[0] = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i == 5) pad_c[0] = 1'b0;
      tick();
      if (reg_rdata[0]) hi_cnt++;
    end
    reg_re = 1'b0;
    check("pulse_in_cycles", 32'(hi_cnt), 32'd5);
    bus_write(3'd7, 32'h0);

    // Random traffic against the model.
    bus_write(3'd3, $urandom);
    bus_write(3'd4, $urandom);
    bus_write(3'd5, $urandom);
    bus_write(3'd7, 32'($urandom_range(0, 3)));
    for (int i = 0; i < 400; i++) begin
      int op;
      pad_c  = pad_c ^ ($urandom & $urandom & $urandom);
      op     = $urandom_range(0, 9);
      reg_we = 1'b0; reg_re = 1'b0;
      if (op <= 2) begin
        reg_addr = 3'($urandom_range(0, 7)); reg_re = 1'b1;
      end else if (op == 3) begin
        reg_addr = 3'd6; reg_wdata = $urandom; reg_we = 1'b1; reg_re = ($urandom_range(0, 1) == 1);
      end else if (op == 4) begin
        reg_addr = 3'($urandom_range(0, 7)); reg_wdata = $urandom; reg_we = 1'b1;
        reg_re = ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    reg_we = 1'b0; reg_re = 1'b0;

    // Pins high through reset must not raise edges; then reset while irq_o is high.
    pad_c = '1;
    apply_reset();
    bus_write(3'd5, 32'hFFFF_FFFF);
    repeat (20) tick();
    bus_read(3'd6, rd);
    check("arm_status", rd, 32'h0);
    bus_read(3'd2, rd);
    check("arm_in", rd, 32'hFFFF_FFFF);
    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_write(3'd1, 32'h0F0F_0000);
    bus_write(3'd0, 32'h1234_5678);
    pad_c[5] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (irq_o) break;
      tick();
    end
    check("irq_before_reset", {31'b0, irq_o}, 32'h1);
    apply_reset();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_pad_bank.md
# gpio_pad_bank

Parametrised GPIO bank between the SoC register bus and a row of bidirectional pad cells. It supersedes the bare per-pin pad wiring. Each pin gets a multi-stage input synchroniser, an optional per-pin glitch filter, edge-detect interrupts (rising, falling or both) with write-1-to-clear status, and an active-low output-enable drive that connects directly to the pad OEN pins. One instance serves up to 32 pins.

## Interface
Parameters:
- N_PINS, 32, number of pins (1..32); register bits [31:N_PINS] read 0, writes ignored
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- FILT_CNT_W, 4, glitch-filter threshold/counter width

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high reset
- reg_addr  in  3  word address of the register
- reg_we  in  1  write strobe
- reg_re  in  1  read strobe
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, registered
- pad_c  in  N_PINS  pad input, from pad C pins (asynchronous)
- pad_i  out  N_PINS  pad output data, to pad I pins
- pad_oen  out  N_PINS  pad output enable, active-low, to pad OEN pins
- irq_o  out  1  level interrupt

## Operation
Register map (reg_addr):
- 0 OUT: output data.
- 1 DIR: 1 = output.
- 2 IN: read-only filtered input.
- 3 IRQ_EN: per-pin interrupt enable.
- 4 IRQ_RISE: 1 = rising edge, 0 = falling edge.
- 5 IRQ_BOTH: 1 = both edges; overrides IRQ_RISE.
- 6 IRQ_STATUS: set on edge; write-1-to-clear.
- 7 FILTER: threshold T in bits [FILT_CNT_W-1:0]; upper bits read 0.

Pad drive:
- pad_i = OUT.
- pad_oen = ~DIR.

Input path, per pin:
- pad_c goes through the SYNC_STAGES flop chain to produce `sync`.
- `sync` goes through the filter to produce `filt`.
- `filt` is registered into `prev`.

Glitch filter, per pin:
- Counter `cnt` is FILT_CNT_W bits wide.
- If sync == filt: cnt <= 0.
- Else if cnt == T: filt <= sync and cnt <= 0.
- Else: cnt <= cnt + 1.
- A pulse shorter than T+1 cycles at `sync` never reaches `filt`.
- Changing T mid-count takes effect on the next cycle's compare. The counter is not cleared.

Edge detect:
- rise = filt & ~prev
- fall = ~filt & prev
- hit = IRQ_BOTH ? (rise | fall) : (IRQ_RISE ? rise : fall)
- IRQ_STATUS is set on hit regardless of IRQ_EN.
- irq_o = |(IRQ_STATUS & IRQ_EN), driven combinationally from flops.

Arming after reset:
- Edge detection is suppressed for the first SYNC_STAGES+2 cycles after reset deasserts, using an arm counter.
- This prevents pins that are high at reset from raising spurious edges.

Simultaneous events:
- A new hit on the same cycle as a W1C of that bit leaves the bit set; set wins.
- A write to any register in the same cycle as a read of it returns the old value.
- reg_we and reg_re may both be asserted in the same cycle.

Bus:
- Writes take effect at the clock edge where reg_we is high.
- IN is read-only; writes to address 2 are ignored.

Reset:
- reg_rdata = 0
- pad_i = 0
- pad_oen = all 1s (all pins are inputs)
- irq_o = 0
- All registers, synchroniser flops, `filt`, `prev` and counters = 0

Reset asserted mid-operation clears all state immediately, asynchronously, and re-arms the arm counter.

## Timing
- reg_rdata is valid on the cycle after reg_re and holds until the next read.
- pad_i and pad_oen change on the cycle after the write.
- Pad change to `sync`: SYNC_STAGES cycles.
- `sync` to `filt`: T+1 cycles, or 0 cycles without the filter.
- `filt` to IRQ_STATUS and irq_o: 1 cycle.
- Total, filter compiled in: SYNC_STAGES+T+2 cycles.
- Total, filter compiled out: SYNC_STAGES+1 cycles.
- A W1C write drops irq_o on the cycle after the write.

## Configuration
- GPIO_GLITCH_FILTER_EN defined: the per-pin filter, its counters and the FILTER register are implemented as described above.
- GPIO_GLITCH_FILTER_EN undefined:
  - filt = sync, wired directly with no filter flops.
  - FILTER reads 0 and writes to it are ignored.
  - Latencies use the filter-compiled-out figures.
  - The arm window is unchanged.

## Test plan
- **Reset and output drive.** Hold reset, then release. Expect pad_oen=0xFFFFFFFF, pad_i=0 and irq_o=0. Then write DIR=0x0000FF00 and OUT=0x0000A500. Expect pad_oen=0xFFFF00FF and pad_i=0x0000A500 on the cycle after each write.
- **Rising-edge interrupt.** With SYNC_STAGES=2 and T=0, set IRQ_EN[3]=1 and IRQ_RISE[3]=1. Drive pad_c[3] 0->1. Expect IRQ_STATUS=0x8 and irq_o=1 exactly 4 cycles later (filter compiled in). Write 0x8 to IRQ_STATUS. Expect irq_o=0 on the next cycle.
- **Glitch rejection (filter compiled in).** Set T=3. A 3-cycle high pulse on pad_c[0] leaves IN[0]=0 with no status bit. A 5-cycle pulse sets IN[0]=1 at sync+4 cycles.
- **Both edges and set-wins.** Set IRQ_BOTH[1]=1. A 1->0 transition sets status bit 1. Issue a W1C of bit 1 on the same cycle a new edge is detected. Expect the bit to remain set.
- **Arming and reset mid-operation.** Hold pad_c=0xFFFFFFFF through reset release. Expect IRQ_STATUS=0 after 20 cycles and IN=0xFFFFFFFF. Then assert reset while irq_o=1. Expect all outputs to return to their reset values immediately.
- **Filter compiled out.** Build without GPIO_GLITCH_FILTER_EN. Write FILTER=0xF. Expect a read of FILTER to return 0. A pad change reaches irq_o in SYNC_STAGES+1=3 cycles.
